blit_dadd_pipe: RTL

- Blitter data adder stage, directly downstream of the data-adder B-operand mux.
- Adds four 16-bit B lanes (srcd, intensity increment or Z increment, as selected upstream) to four 16-bit A lanes.
- Modes: independent 16-bit wrap, paired 32-bit with carry chained between lanes, or per-lane intensity saturation.
- Two-stage valid/ready pipeline; results feed the intensity/Z data registers and the write-data path.

---
 rtl/blit_dadd_pipe_pkg.sv | 26 ++
 rtl/blit_dadd_pipe_lane.sv | 42 ++++
 rtl/blit_dadd_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/blit_dadd_pipe_pkg.sv
// rtl/blit_dadd_pipe_pkg.sv - shared blitter data-adder constants, mode encodings and stage-1 lane record
package blit_dadd_pipe_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int HALF_W = LANE_W / 2;

    typedef enum logic [1:0] {
        DADD_WRAP16 = 2'd0,
        DADD_PAIR32 = 2'd1,
        DADD_SAT    = 2'd2,
        DADD_PASS   = 2'd3
    } dadd_mode_e;

    localparam logic [LANE_W-1:0] SAT_MAX = '1;
    localparam logic [LANE_W-1:0] SAT_MIN = '0;

    // Low byte is already summed; upper operands ride along for stage 2.
    typedef struct packed {
        logic [HALF_W-1:0] lo;
        logic              c8;
        logic [HALF_W-1:0] a_hi;
        logic [HALF_W-1:0] b_hi;
    } s1_lane_t;

endpackage

// File: rtl/blit_dadd_pipe_lane.sv
// rtl/blit_dadd_pipe_lane.sv - one lane of stage 2: upper-byte add, pair carry-in, clamp (BLIT_DADD_SAT_EN)
module blit_dadd_lane
    import blit_dadd_pipe_pkg::*;
#(
    parameter bit CHAIN_IN = 1'b0
) (
    input  s1_lane_t          lane,
    input  dadd_mode_e        mode,
    input  logic              chain_cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout
);

    logic              cin;
    logic [HALF_W:0]   lo_full;
    logic [HALF_W:0]   hi_full;

    always_comb begin
        cin     = CHAIN_IN && (mode == DADD_PAIR32) && chain_cin;
        // c8 and a carry out of lo+cin can never both be set, so OR is exact
        lo_full = {1'b0, lane.lo} + {{HALF_W{1'b0}}, cin};
        hi_full = {1'b0, lane.a_hi} + {1'b0, lane.b_hi}
                + {{HALF_W{1'b0}}, lane.c8 | lo_full[HALF_W]};
        sum     = {hi_full[HALF_W-1:0], lo_full[HALF_W-1:0]};
        cout    = hi_full[HALF_W];
        if (mode == DADD_PASS) begin
            // stage 1 zeroed the low B byte, so lo already holds A's low byte
            sum  = {lane.a_hi, lane.lo};
            cout = 1'b0;
        end
`ifdef BLIT_DADD_SAT_EN
        else if (mode == DADD_SAT) begin
            if (!lane.b_hi[HALF_W-1] && hi_full[HALF_W]) begin
                sum = SAT_MAX;
            end else if (lane.b_hi[HALF_W-1] && !hi_full[HALF_W]) begin
                sum = SAT_MIN;
            end
        end
`endif
    end

endmodule

// File: rtl/blit_dadd_pipe.sv
// rtl/blit_dadd_pipe.sv - two-stage blitter data adder, wrap/pair32/saturate/pass modes (saturate gated by BLIT_DADD_SAT_EN)
module blit_dadd_pipe
    import blit_dadd_pipe_pkg::*;
(
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [LANE_W-1:0] adda_0,
    input  logic [LANE_W-1:0] adda_1,
    input  logic [LANE_W-1:0] adda_2,
    input  logic [LANE_W-1:0] adda_3,
    input  logic [LANE_W-1:0] addb_0,
    input  logic [LANE_W-1:0] addb_1,
    input  logic [LANE_W-1:0] addb_2,
    input  logic [LANE_W-1:0] addb_3,
    input  logic [1:0]        daddmode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] sum_0,
    output logic [LANE_W-1:0] sum_1,
    output logic [LANE_W-1:0] sum_2,
    output logic [LANE_W-1:0] sum_3,
    output logic [LANES-1:0]  cout,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [LANE_W-1:0] a [LANES];
    logic [LANE_W-1:0] b [LANES];

    assign a[0] = adda_0;
    assign a[1] = adda_1;
    assign a[2] = adda_2;
    assign a[3] = adda_3;
    assign b[0] = addb_0;
    assign b[1] = addb_1;
    assign b[2] = addb_2;
    assign b[3] = addb_3;

    s1_lane_t          s1_lane_d [LANES];
    s1_lane_t          s1_lane_q [LANES];
    dadd_mode_e        s1_mode;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_advance;
    logic              s1_pass;
    logic [LANE_W-1:0] s2_sum_d [LANES];
    logic [LANE_W-1:0] s2_sum_q [LANES];
    logic [LANES-1:0]  s2_cout_d;
    logic [LANES-1:0]  s2_cout_q;

    assign s2_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign s1_pass    = (daddmode == DADD_PASS);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_lane_d[i].a_hi = a[i][LANE_W-1:HALF_W];
            s1_lane_d[i].b_hi = b[i][LANE_W-1:HALF_W];
            {s1_lane_d[i].c8, s1_lane_d[i].lo} = {1'b0, a[i][HALF_W-1:0]}
                + {1'b0, (s1_pass ? {HALF_W{1'b0}} : b[i][HALF_W-1:0])};
        end
    end

    // Lanes are paired (even, odd); the odd lane may take the even lane's carry.
    for (genvar p = 0; p < LANES / 2; p++) begin : g_pair
        logic lo_cout;
        logic hi_cout;

        blit_dadd_lane #(.CHAIN_IN(1'b0)) u_lane_lo (
            .lane      (s1_lane_q[2*p]),
            .mode      (s1_mode),
            .chain_cin (1'b0),
            .sum       (s2_sum_d[2*p]),
            .cout      (lo_cout)
        );

        blit_dadd_lane #(.CHAIN_IN(1'b1)) u_lane_hi (
            .lane      (s1_lane_q[2*p+1]),
            .mode      (s1_mode),
            .chain_cin (lo_cout),
            .sum       (s2_sum_d[2*p+1]),
            .cout      (hi_cout)
        );

        assign s2_cout_d[2*p]   = lo_cout;
        assign s2_cout_d[2*p+1] = hi_cout;
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_mode   <= DADD_WRAP16;
            s2_cout_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_lane_q[i] <= '0;
                s2_sum_q[i]  <= '0;
            end
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mode <= dadd_mode_e'(daddmode);
                    for (int i = 0; i < LANES; i++) begin
                        s1_lane_q[i] <= s1_lane_d[i];
                    end
                end
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_cout_q <= s2_cout_d;
                    for (int i = 0; i < LANES; i++) begin
                        s2_sum_q[i] <= s2_sum_d[i];
                    end
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign cout      = s2_cout_q;
    assign sum_0     = s2_sum_q[0];
    assign sum_1     = s2_sum_q[1];
    assign sum_2     = s2_sum_q[2];
    assign sum_3     = s2_sum_q[3];

endmodule
